// File: rtl/galaksija_tape_pkg.sv
// Shared types and constants for the Galaksija cassette playback engine.
package galaksija_tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BITS,
        GAP,
        DONE
    } tape_state_t;

    localparam int TICKS_PER_BIT = 8;
    localparam int BITS_PER_BYTE = 8;
    localparam int SYNC_TICK     = 0;
    localparam int DATA_TICK     = 4;

endpackage

// File: rtl/galaksija_tape_buf_dp.sv
// Tape image buffer: simple dual-port RAM, one write port and one registered read port.
module galaksija_tape_buf_dp #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/galaksija_tape_player.sv
// Captures a downloaded tape image and replays it as a Galaksija pulse stream.
module galaksija_tape_player
    import galaksija_tape_pkg::*;
#(
    parameter int ADDR_W          = 14,
    parameter int TICK_CYCLES     = 1150,
    parameter int BYTE_GAP_CYCLES = 13000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              stop,
    input  logic              pause,
    output logic              tape_bit,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] addr_max,
    output logic [ADDR_W-1:0] play_addr
);

    localparam int CYC_W  = $clog2(TICK_CYCLES + 1);
    localparam int GAP_W  = $clog2(BYTE_GAP_CYCLES + 1);
    localparam int TICK_W = $clog2(TICKS_PER_BIT);
    localparam int BIT_W  = $clog2(BITS_PER_BYTE);

    tape_state_t       state, next_state;
    logic              dl_prev;
    logic              loaded;
    logic              fetch_ph;
    logic [CYC_W-1:0]  cyc;
    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_idx;
    logic [GAP_W-1:0]  gap;
    logic [7:0]        shreg;
    logic [7:0]        rd_data;

    logic dl_rise, dl_fall, wr_en, abort, start;
    logic cyc_last, tick_last, bit_last, gap_last, last_byte;

    assign dl_rise   = dl_active & ~dl_prev;
    assign dl_fall   = ~dl_active & dl_prev;
    assign wr_en     = dl_active & dl_wr;
    assign abort     = (state != IDLE) && (stop || dl_rise);
    assign start     = (state == IDLE) && dl_fall && loaded && !stop;
    assign cyc_last  = (cyc == CYC_W'(TICK_CYCLES - 1));
    assign tick_last = (tick == TICK_W'(TICKS_PER_BIT - 1));
    assign bit_last  = (bit_idx == BIT_W'(BITS_PER_BYTE - 1));
    assign gap_last  = (gap == GAP_W'(BYTE_GAP_CYCLES - 1));
    assign last_byte = (play_addr == addr_max);

    galaksija_tape_buf_dp #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (dl_addr),
        .wr_data (dl_data),
        .rd_addr (play_addr),
        .rd_data (rd_data)
    );

    // A write in the same cycle as the rising edge still counts toward the new image.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dl_prev  <= 1'b0;
            loaded   <= 1'b0;
            addr_max <= '0;
        end else begin
            dl_prev <= dl_active;
            if (dl_rise) begin
                loaded   <= 1'b0;
                addr_max <= '0;
            end
            if (wr_en) begin
                loaded   <= 1'b1;
                addr_max <= dl_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tape_bit   = 1'b1;
        playing    = 1'b0;
        done       = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) next_state = FETCH;
                FETCH: if (fetch_ph) next_state = BITS;
                BITS:  if (!pause && cyc_last && tick_last && bit_last) next_state = GAP;
                GAP:   if (!pause && gap_last) next_state = last_byte ? DONE : FETCH;
                DONE:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
        case (state)
            FETCH, GAP: playing = 1'b1;
            BITS: begin
                playing = 1'b1;
                if (tick == TICK_W'(SYNC_TICK) || (tick == TICK_W'(DATA_TICK) && shreg[0])) begin
                    tape_bit = 1'b0;
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // FETCH spends its first cycle waiting on the RAM read, the second latching the byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            play_addr <= '0;
            fetch_ph  <= 1'b0;
            cyc       <= '0;
            tick      <= '0;
            bit_idx   <= '0;
            gap       <= '0;
            shreg     <= '0;
        end else if (abort) begin
            fetch_ph <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        play_addr <= '0;
                    end
                end
                FETCH: begin
                    fetch_ph <= ~fetch_ph;
                    gap      <= '0;
                    if (fetch_ph) begin
                        shreg   <= rd_data;
                        cyc     <= '0;
                        tick    <= '0;
                        bit_idx <= '0;
                    end
                end
                BITS: begin
                    if (!pause) begin
                        if (cyc_last) begin
                            cyc <= '0;
                            if (tick_last) begin
                                tick    <= '0;
                                bit_idx <= bit_idx + 1'b1;
                                shreg   <= shreg >> 1;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (gap_last) begin
                            gap <= '0;
                            if (!last_byte) begin
                                play_addr <= play_addr + 1'b1;
                            end
                        end else begin
                            gap <= gap + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_galaksija_tape_player.sv
// Directed bench for galaksija_tape_player with short tick and gap lengths.
module tb_galaksija_tape_player;

    localparam int AW   = 4;
    localparam int TC   = 2;
    localparam int GC   = 4;
    localparam int BP   = 2 + 64 * TC + GC;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          tape_bit, playing, done;
    logic [AW-1:0] addr_max, play_addr;

    int checks = 0;
    int errors = 0;

    logic          wave   [MAXC];
    logic [AW-1:0] pa_log [MAXC];
    logic [7:0]    img    [4];
    int            done_at, n_done, n_cyc;
    int            pause_at  = -1;
    int            pause_len = 0;

    galaksija_tape_player #(
        .ADDR_W          (AW),
        .TICK_CYCLES     (TC),
        .BYTE_GAP_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .stop      (stop),
        .pause     (pause),
        .tape_bit  (tape_bit),
        .playing   (playing),
        .done      (done),
        .addr_max  (addr_max),
        .play_addr (play_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture img[0..n-1] at base..base+n-1, then drop dl_active (optionally with stop).
    task automatic load(input int n, input int base, input logic stop_end);
        dl_active = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            dl_wr   = 1'b1;
            dl_addr = AW'(base + i);
            dl_data = img[i];
            step();
        end
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        stop      = stop_end;
        step();
        stop = 1'b0;
    endtask

    task automatic run_play();
        done_at = -1;
        n_done  = 0;
        n_cyc   = 0;
        for (int i = 0; i < MAXC; i++) begin
            if (i == pause_at) pause = 1'b1;
            if (i == pause_at + pause_len) pause = 1'b0;
            wave[i]   = tape_bit;
            pa_log[i] = play_addr;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end
            if (!playing && !done) begin
                n_cyc = i;
                break;
            end
            step();
        end
        pause    = 1'b0;
        pause_at = -1;
        check("play_end", 32'(n_cyc != 0), 32'd1);
    endtask

    function automatic logic exp_tape(input logic [7:0] b, input int off);
        int rel, bi, t;
        if (off < 2 || off >= 2 + 64 * TC) return 1'b1;
        rel = off - 2;
        bi  = rel / (8 * TC);
        t   = (rel / TC) % 8;
        return !(t == 0 || (t == 4 && b[bi]));
    endfunction

    function automatic int wave_err(input int nbytes);
        int e = 0;
        for (int i = 0; i < nbytes * BP; i++) begin
            if (wave[i] !== exp_tape(img[i / BP], i % BP)) e++;
        end
        return e;
    endfunction

    function automatic int count_low(input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) begin
            if (wave[i] == 1'b0) c++;
        end
        return c;
    endfunction

    initial begin
        #3;
        check("rst_tape", 32'(tape_bit), 32'd1);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr_max", 32'(addr_max), 32'd0);
        check("rst_play_addr", 32'(play_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Single byte A5
        img[0] = 8'hA5;
        load(1, 0, 1'b0);
        check("a5_playing_rise", 32'(playing), 32'd1);
        run_play();
        check("a5_done_at", 32'(done_at), 32'd134);
        check("a5_n_done", 32'(n_done), 32'd1);
        check("a5_addr_max", 32'(addr_max), 32'd0);
        check("a5_wave", 32'(wave_err(1)), 32'd0);
        check("a5_lows", 32'(count_low(0, BP)), 32'd24);
        check("a5_b0_t4", 32'(wave[10]), 32'd0);
        check("a5_b1_t4", 32'(wave[26]), 32'd1);

        // Three bytes 01, 80, FF
        img[0] = 8'h01; img[1] = 8'h80; img[2] = 8'hFF;
        load(3, 0, 1'b0);
        run_play();
        check("m3_addr_max", 32'(addr_max), 32'd2);
        check("m3_done_at", 32'(done_at), 32'd402);
        check("m3_n_done", 32'(n_done), 32'd1);
        check("m3_pa0", 32'(pa_log[0]), 32'd0);
        check("m3_pa1", 32'(pa_log[134]), 32'd1);
        check("m3_pa2", 32'(pa_log[268]), 32'd2);
        check("m3_wave", 32'(wave_err(3)), 32'd0);
        check("m3_ff_lows", 32'(count_low(268, 402)), 32'd32);
        check("m3_play_addr_end", 32'(play_addr), 32'd2);
        check("m3_playing_end", 32'(playing), 32'd0);

        // Mid-byte stop, then a dl_active pulse with no writes
        img[0] = 8'h5A;
        load(1, 2, 1'b0);
        for (int i = 0; i < 40; i++) step();
        check("stop_pre_addr_max", 32'(addr_max), 32'd2);
        check("stop_pre_playing", 32'(playing), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_tape", 32'(tape_bit), 32'd1);
        check("stop_playing", 32'(playing), 32'd0);
        n_done = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) n_done++;
            step();
        end
        check("stop_no_done", 32'(n_done), 32'd0);
        dl_active = 1'b1;
        step();
        check("rise_addr_max", 32'(addr_max), 32'd0);
        dl_active = 1'b0;
        step();
        check("empty_playing0", 32'(playing), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("empty_playing5", 32'(playing), 32'd0);

        // Pause for 10 cycles at bit 0 tick 4 of A5
        img[0] = 8'hA5;
        pause_at  = 10;
        pause_len = 10;
        load(1, 0, 1'b0);
        run_play();
        check("pause_done_at", 32'(done_at), 32'd144);
        check("pause_lows", 32'(count_low(0, BP + 10)), 32'd34);
        check("pause_last_low", 32'(wave[21]), 32'd0);
        check("pause_after", 32'(wave[22]), 32'd1);

        // Asynchronous reset in the gap of the second byte
        img[0] = 8'hA5; img[1] = 8'h3C;
        load(2, 0, 1'b0);
        for (int i = 0; i < BP + 131; i++) step();
        check("gap_play_addr", 32'(play_addr), 32'd1);
        check("gap_playing", 32'(playing), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_tape", 32'(tape_bit), 32'd1);
        check("arst_playing", 32'(playing), 32'd0);
        check("arst_addr_max", 32'(addr_max), 32'd0);
        check("arst_play_addr", 32'(play_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Stop coincident with the end of download
        img[0] = 8'hA5;
        load(1, 0, 1'b1);
        check("stopfall_playing", 32'(playing), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("stopfall_playing5", 32'(playing), 32'd0);

        // Image ending at the top address must stop there, not wrap
        img[0] = 8'h00;
        load(1, 15, 1'b0);
        check("top_addr_max", 32'(addr_max), 32'd15);
        run_play();
        check("top_done_at", 32'(done_at), 32'(16 * BP));
        check("top_n_done", 32'(n_done), 32'd1);
        check("top_play_addr", 32'(play_addr), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/galaksija_tape_player.md
Name: galaksija_tape_player

Overview:
- Cassette playback engine that replaces the inline tape logic in the top level.
- Captures a downloaded tape image (ioctl stream) into an internal buffer. When the download ends, it replays the image as a Galaksija-format pulse stream.
- tape_bit feeds the CPU read of $2000 and the audio monitor. addr_max/play_addr drive the video progress bar.
- Sits between the ioctl loader (upstream) and the top-level CPU data mux (downstream).

Parameters:
- ADDR_W, 14: buffer address width; capacity 2^ADDR_W bytes.
- TICK_CYCLES, 1150: clk cycles per tick; 8 ticks form one bit cell.
- BYTE_GAP_CYCLES, 13000: idle-high cycles inserted after each byte.

Ports:
- clk, in, 1: single clock.
- resetn, in, 1: asynchronous active-low reset.
- dl_active, in, 1: download in progress.
- dl_wr, in, 1: download byte strobe; qualified by dl_active.
- dl_addr, in, ADDR_W: download byte address.
- dl_data, in, 8: download byte.
- stop, in, 1: abort playback.
- pause, in, 1: freeze playback timing.
- tape_bit, out, 1: pulse stream; idle level 1.
- playing, out, 1: playback active.
- done, out, 1: one-cycle pulse when the last byte finishes.
- addr_max, out, ADDR_W: highest address written during the last download.
- play_addr, out, ADDR_W: byte currently being played.

Behaviour:
Reset state:
- All outputs: tape_bit=1, playing=0, done=0, addr_max=0, play_addr=0. FSM=IDLE; counters 0; the "loaded" flag is 0.
- Buffer contents are not reset.

Capture:
- Any cycle with dl_active&dl_wr writes dl_data to buf[dl_addr], sets loaded=1 and sets addr_max<=dl_addr (the last written address wins, not the maximum).
- dl_active rising clears loaded and addr_max to 0 in the same cycle.

Start condition:
- Falling edge of dl_active (registered previous value) with loaded=1 -> FETCH, play_addr=0.
- If loaded=0 on that edge, the FSM stays in IDLE.

FSM states:
- IDLE: tape_bit=1, playing=0.
- FETCH: issue buffer read at play_addr; the 1-cycle RAM latency is absorbed here. Next cycle: latch byte into shift register -> BITS with bit_idx=0, tick=0, cyc=0. tape_bit=1 during FETCH.
- BITS: cyc counts 0..TICK_CYCLES-1; on wrap, tick increments 0..7; on tick wrap, bit_idx increments 0..7. Bits are sent LSB first.
  - tape_bit=0 when tick==0 (sync pulse).
  - tape_bit=0 when tick==4 and the current bit is 1.
  - tape_bit=1 otherwise.
  - After bit 7 tick 7 completes -> GAP.
- GAP: tape_bit=1 for BYTE_GAP_CYCLES cycles.
  - If play_addr==addr_max -> DONE.
  - Otherwise play_addr+1 -> FETCH.
- DONE: done=1 for one cycle -> IDLE; play_addr holds its final value.

Timing:
- playing=1 in FETCH/BITS/GAP.
- Bytes are back-to-back, so one byte period = 2 + 64*TICK_CYCLES + BYTE_GAP_CYCLES cycles.

Boundary conditions:
- pause=1: cyc, tick, bit and gap counters all hold, and tape_bit holds its current value. FETCH still completes.
- stop=1 in any non-IDLE state -> IDLE next cycle with tape_bit=1; no done pulse.
- stop and a dl_active falling edge in the same cycle: stop wins and playback does not start.
- dl_active rising during playback: abort to IDLE (no done) and begin a new capture.
- addr_max = 2^ADDR_W-1: play_addr must not wrap. It terminates on equality.
- A single-byte image (addr_max=0) plays exactly one byte.
- Asynchronous reset mid-byte: tape_bit=1 immediately.

Decomposition:
- Package galaksija_tape_pkg holds:
  - the state enum (IDLE, FETCH, BITS, GAP, DONE);
  - localparams TICKS_PER_BIT=8, BITS_PER_BYTE=8, SYNC_TICK=0, DATA_TICK=4.
- One sub-module galaksija_tape_buf_dp:
  - simple dual-port RAM, 2^ADDR_W x 8, same clock;
  - write port for capture, registered read port for playback;
  - no reset on the array.

Test Plan:
- Setup: TICK_CYCLES=2, BYTE_GAP_CYCLES=4.
- Download 8'hA5 to addr 0, then drop dl_active:
  - playing rises 1 cycle later;
  - tape_bit low at ticks 0 of every bit, and low at tick 4 only for bits 0,2,5,7;
  - done pulses after 2+128+4 cycles; addr_max=0.
- Download 3 bytes {01,80,FF} to addrs 0..2:
  - play_addr steps 0,1,2;
  - the 8'hFF byte shows 16 low ticks;
  - single done pulse; playing then 0.
- Mid-byte stop=1:
  - next cycle tape_bit=1, playing=0, no done.
  - A new dl_active rising clears addr_max to 0.
- pause held 10 cycles during tick 4 of a 1-bit:
  - tape_bit stays 0 for 10 extra cycles;
  - total byte period lengthens by exactly 10.
- dl_active pulse with no dl_wr: no playback, playing stays 0.
- Assert resetn=0 mid-GAP: outputs return to their reset values immediately.
- Stop and download-end in the same cycle: remains IDLE.
